resp_sig_checker: RTL
=====================

# resp_sig_checker

Response-side companion to the exhaustive stimulus sweep used on small combinational circuits. After a start pulse it samples 2^CNT_W DUT response vectors, one per valid cycle, and compacts them into a multiple-input signature register (MISR). At the end of the sweep it compares the signature against a golden value and reports pass/fail, so a sweep can be checked in hardware instead of by reading a waveform.

## Interface
- CNT_W, 3, width of the sample counter; a sweep is 2^CNT_W samples
- RESP_W, 2, response vector width; must be at most SIG_W
- SIG_W, 8, MISR width
- POLY, 8'h1D, MISR feedback polynomial taps, SIG_W bits
- SEED, 8'h00, MISR value loaded at reset and at each start
- GOLDEN, 8'h00, expected final signature
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle request to begin a sweep
- resp_valid  in  1  qualifies `resp` this cycle
- resp  in  RESP_W  DUT response sample
- busy  out  1  high while in RUN
- done  out  1  high in DONE
- pass  out  1  valid only when done=1; high when signature == GOLDEN
- signature  out  SIG_W  current MISR contents
- count  out  CNT_W  number of samples taken in the current sweep, modulo 2^CNT_W

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads the MISR with SEED, clears count and moves to RUN.
  - resp_valid is ignored.
- RUN:
  - On each cycle with resp_valid=1, update the MISR: sig_next = (sig << 1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended resp. Then increment count.
  - If the sample just taken is number 2^CNT_W, move to DONE. count wraps to 0.
  - A cycle with resp_valid=0 holds all state.
- DONE:
  - done=1.
  - pass is registered as (signature == GOLDEN) on the same edge that enters DONE.
  - Stay in DONE until start=1, which behaves exactly like start in IDLE.
- start while in RUN is ignored; the current sweep is not restarted.
- If start and resp_valid are high in the same cycle in IDLE or DONE, the sample is not captured. The first sample is taken on the following valid cycle.
- Reset, including reset in the middle of a sweep, returns to IDLE:
  - signature=SEED
  - count=0
  - busy=0, done=0, pass=0

## Timing
- All outputs come directly from registers; there is no combinational path from input to output.
- start sampled at edge N gives busy=1 after edge N.
- The last valid sample, at edge M, gives busy=0, done=1 and a valid pass after edge M. Latency from the last sample to the result is one edge.
- With resp_valid held high, a sweep takes 2^CNT_W + 1 cycles from start to done, which is 9 cycles at default parameters.
- Reset is asserted asynchronously. Deassertion is expected to be synchronous to clk; synchronizing it is the system's job.

## Structure
- Put the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) in a shared include of constants.
- Put the default POLY and SEED in the same include, so stimulus-side blocks can reuse them.
- One sub-module: misr_reg, parameterised by SIG_W, RESP_W, POLY and SEED, with ports for load, enable and data in.
- The top level holds the FSM, count and compare.

## Test plan
All scenarios use default parameters with resp_valid held high unless stated otherwise.
- Reset mid-sweep:
  - Stimulus: start, 3 samples of resp=2'b11, then rst_n=0 for 1 cycle.
  - Response: busy=0, done=0, pass=0, count=0, signature=8'h00, applied immediately without waiting for a clock edge.
- All-zero sweep:
  - Stimulus: start, then 8 samples of resp=2'b00.
  - Response: signature=8'h00; done=1 on the 9th edge after start; pass=1 (GOLDEN=8'h00).
- Constant ones:
  - Stimulus: 8 samples of resp=2'b01.
  - Response: signature steps through 01, 03, 07, 0F, 1F, 3F, 7F, FF; ends at 8'hFF with pass=0.
- Single one, then zeros:
  - Stimulus: resp=2'b01 on the first sample, then 7 samples of 2'b00.
  - Response: final signature=8'h80.
  - Variant: add a 9th sweep by setting CNT_W=4 with 8 more zero samples. Feedback then gives 8'h1D after the 9th shift.
- Gapped valid:
  - Stimulus: the all-zero sweep with resp_valid toggling every other cycle.
  - Response: done after 16 cycles; count and signature hold during the gaps.
- Start handling:
  - Stimulus: start pulsed mid-RUN, then start pulsed while in DONE.
  - Response: the mid-RUN start is ignored and count keeps increasing. The start in DONE restarts: done=0, busy=1, signature=SEED, count=0.

Source files
------------

// File: rtl/resp_sig_checker_pkg.sv
// resp_sig_checker_pkg
//   Shared constants for the response signature checker and for any
//   stimulus-side block that wants the same MISR defaults.
//   - state_t      : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - DEF_POLY     : default MISR feedback taps
//   - DEF_SEED     : default MISR load value
//   - DEF_GOLDEN   : default expected final signature
package resp_sig_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] DEF_POLY   = 8'h1D;
  localparam logic [7:0] DEF_SEED   = 8'h00;
  localparam logic [7:0] DEF_GOLDEN = 8'h00;

endpackage

// File: rtl/resp_sig_checker_misr.sv
// misr_reg
//   Multiple-input signature register. Each enabled cycle shifts left,
//   folds the outgoing MSB back through POLY and XORs in the
//   zero-extended response word.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (loads SEED)
//     load       : synchronous reload with SEED (wins over en)
//     en         : compact din this cycle
//     din        : RESP_W response sample
//     sig        : registered signature
//     sig_next   : value sig takes if en is applied this cycle
module misr_reg
  import resp_sig_checker_pkg::*;
#(
  parameter int                SIG_W  = 8,
  parameter int                RESP_W = 2,
  parameter logic [SIG_W-1:0]  POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0]  SEED   = SIG_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [SIG_W-1:0]  sig,
  output logic [SIG_W-1:0]  sig_next
);

  logic [SIG_W-1:0] din_ext;

  always_comb begin
    din_ext              = '0;
    din_ext[RESP_W-1:0]  = din;
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/resp_sig_checker.sv
// resp_sig_checker
//   Compacts 2^CNT_W valid response samples into a MISR after a start
//   pulse and compares the final signature with GOLDEN.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     start       : begin a sweep (honoured in IDLE and DONE only)
//     resp_valid  : qualifies resp
//     resp        : response sample
//     busy        : high in RUN
//     done        : high in DONE
//     pass        : signature matched GOLDEN (meaningful while done=1)
//     signature   : current MISR contents
//     count       : samples taken this sweep, modulo 2^CNT_W
//     fsm_state   : current FSM state, for observation
//   Handshake: a sample is consumed on every rising edge where the FSM is
//   in RUN and resp_valid=1; there is no backpressure.
module resp_sig_checker
  import resp_sig_checker_pkg::*;
#(
  parameter int               CNT_W  = 3,
  parameter int               RESP_W = 2,
  parameter int               SIG_W  = 8,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
  parameter logic [SIG_W-1:0] GOLDEN = SIG_W'(DEF_GOLDEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  count,
  output logic [1:0]        fsm_state
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             misr_load, misr_en;
  logic [SIG_W-1:0] sig_next;

  misr_reg #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (misr_load),
    .en       (misr_en),
    .din      (resp),
    .sig      (signature),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    case (state_q)
      // A start cycle only arms the sweep; a coincident sample is dropped.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          misr_load = 1'b1;
          cnt_d     = '0;
          pass_d    = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (resp_valid) begin
          misr_en = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          // count at all-ones means this is sample 2^CNT_W; count wraps to 0.
          if (cnt_q == '1) begin
            state_d = ST_DONE;
            pass_d  = (sig_next == GOLDEN);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign count     = cnt_q;
  assign fsm_state = state_q;

endmodule
